mc_refresh_scheduler: RTL and testbench
=======================================

// Module: mc_refresh_scheduler
// PURPOSE
//  Periodic DRAM refresh scheduler for the memory controller. Generates refresh
//  requests every tREFI, tracks postponed refreshes and raises urgency, and
//  holds off other commands for tRFC after each issued REF. It also drains
//  pending refreshes and enters/exits self-refresh on request from power mgmt.
//  Sits between MC_PowerManagement and the command scheduler.
// PARAMETERS
//  TREFI_CYC     7800  clk cycles between refresh ticks (>=2)
//  TRFC_CYC      350   clk cycles busy_trfc stays high after a REF ack (>=1)
//  MAX_POSTPONE  8     max outstanding refreshes (1..15); pending saturates here
// PORTS
//  clk           in   1   clock, all logic on posedge
//  reset         in   1   synchronous, active-high
//  enable        in   1   refresh tick counter runs when 1; holds when 0
//  ref_ack       in   1   scheduler issued REF (honoured only while ref_req=1)
//  sr_req        in   1   request self-refresh entry (level)
//  sr_exit       in   1   request self-refresh exit (pulse, honoured in SR only)
//  ref_req       out  1   refresh wanted (pending>0, state IDLE)
//  ref_urgent    out  1   pending == MAX_POSTPONE; scheduler must issue REF next
//  busy_trfc     out  1   tRFC window active; no other DRAM commands allowed
//  sr_active     out  1   device in self-refresh
//  pending_cnt   out  4   outstanding refresh count
//  ref_overflow  out  1   sticky: tick arrived with pending == MAX_POSTPONE
// BEHAVIOUR
//  - Reset: state IDLE, tick counter = TREFI_CYC-1, pending 0, all outputs 0.
//  - All outputs are decodes of registered state; no input->output comb paths.
//  - Tick counter: in IDLE/TRFC with enable=1 decrements; at 0 reloads
//    TREFI_CYC-1 and generates a tick that same cycle. enable=0 freezes it.
//  - Tick: pending+1, saturating at MAX_POSTPONE; tick at saturation sets
//    ref_overflow (cleared only by reset); pending stays MAX_POSTPONE.
//  - States: IDLE, TRFC, SR.
//    IDLE: ref_req = (pending!=0). ref_ack with ref_req=1 -> pending-1,
//      go TRFC. Else sr_req=1 and pending==0 -> SR. Else stay IDLE.
//      sr_req with pending>0: stay IDLE, keep requesting (drain first).
//    TRFC: busy_trfc=1 for exactly TRFC_CYC cycles starting the cycle after
//      the ack edge, then IDLE. ref_req=0; ref_ack ignored; ticks still count.
//    SR: sr_active=1; tick counter held at TREFI_CYC-1; pending held 0.
//      sr_exit=1 -> IDLE with pending=1 (one post-exit REF owed).
//  - Tick and accepted ack in same cycle: pending net unchanged (at
//    saturation: no overflow, since a slot is freed the same cycle).
//  - ref_urgent = (pending==MAX_POSTPONE), valid in any state except SR.
//  - sr_exit outside SR and ref_ack outside IDLE/ref_req=1 are ignored.
//  - reset mid-TRFC or mid-SR: returns to reset values next cycle.
// CONFIGURATION
//  MC_REF_URGENT_STATS_EN defined: adds output urgent_cycles [15:0], counts
//    cycles with ref_urgent=1, saturates at 16'hFFFF, cleared by reset.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING (TREFI_CYC=16, TRFC_CYC=4, MAX_POSTPONE=4)
//  Reset, enable=1, no ack -> first ref_req rise 16 cycles after reset
//    release, pending_cnt=1.
//  Ack the cycle after ref_req rises -> ref_req=0, busy_trfc high exactly 4
//    cycles, pending_cnt=0.
//  No ack for 64 cycles -> pending 4, ref_urgent=1; next tick -> ref_overflow=1.
//  Ack on tick cycle with pending=4 -> pending stays 4, ref_overflow stays 0.
//  sr_req with pending=2 -> two ack/TRFC rounds, then sr_active=1;
//    sr_exit -> sr_active=0, ref_req=1, pending_cnt=1.
//  Assert reset mid-TRFC -> busy_trfc=0, pending 0 next cycle. With the
//    macro, urgent_cycles counts urgent cycles; without it, the port is absent.

Source files
------------

// File: rtl/mc_refresh_scheduler.sv
// Periodic DRAM refresh scheduler: tREFI tick generation, postponed-refresh tracking, tRFC hold-off, self-refresh entry/exit.
// Optional urgency statistics counter when MC_REF_URGENT_STATS_EN is defined.
module mc_refresh_scheduler #(
  parameter int TREFI_CYC    = 7800,
  parameter int TRFC_CYC     = 350,
  parameter int MAX_POSTPONE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ref_ack,
  input  logic        sr_req,
  input  logic        sr_exit,
  output logic        ref_req,
  output logic        ref_urgent,
  output logic        busy_trfc,
  output logic        sr_active,
  output logic [3:0]  pending_cnt,
  output logic        ref_overflow
`ifdef MC_REF_URGENT_STATS_EN
  ,
  output logic [15:0] urgent_cycles
`endif
);

  localparam int CW = (TREFI_CYC > 2) ? $clog2(TREFI_CYC) : 1;
  localparam int TW = (TRFC_CYC > 1) ? $clog2(TRFC_CYC) : 1;
  localparam logic [CW-1:0] TICK_RELOAD = CW'(TREFI_CYC - 1);
  localparam logic [TW-1:0] TRFC_LAST   = TW'(TRFC_CYC - 1);
  localparam logic [3:0]    MAX_P       = 4'(MAX_POSTPONE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRFC = 2'd1,
    ST_SR   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [TW-1:0] trfc_cnt_q, trfc_cnt_d;
  logic [3:0]    pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic          tick;
  logic          ack_ok;

  assign tick   = (state_q != ST_SR) && enable && (tick_cnt_q == '0);
  assign ack_ok = (state_q == ST_IDLE) && (pending_q != 4'd0) && ref_ack;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    trfc_cnt_d = trfc_cnt_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    if (state_q == ST_SR) begin
      tick_cnt_d = TICK_RELOAD;
    end else if (enable) begin
      tick_cnt_d = tick ? TICK_RELOAD : tick_cnt_q - CW'(1);
    end

    // A tick coinciding with an accepted REF frees and refills the same slot.
    if (tick && !ack_ok) begin
      if (pending_q == MAX_P) overflow_d = 1'b1;
      else                    pending_d  = pending_q + 4'd1;
    end else if (!tick && ack_ok) begin
      pending_d = pending_q - 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ack_ok) begin
          state_d    = ST_TRFC;
          trfc_cnt_d = TRFC_LAST;
        end else if (sr_req && (pending_q == 4'd0)) begin
          state_d   = ST_SR;
          pending_d = 4'd0;
        end
      end
      ST_TRFC: begin
        if (trfc_cnt_q == '0) state_d    = ST_IDLE;
        else                  trfc_cnt_d = trfc_cnt_q - TW'(1);
      end
      ST_SR: begin
        // One refresh is owed immediately after leaving self-refresh.
        pending_d = sr_exit ? 4'd1 : 4'd0;
        if (sr_exit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= TICK_RELOAD;
      trfc_cnt_q <= '0;
      pending_q  <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      trfc_cnt_q <= trfc_cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign ref_req      = (state_q == ST_IDLE) && (pending_q != 4'd0);
  assign ref_urgent   = (state_q != ST_SR) && (pending_q == MAX_P);
  assign busy_trfc    = (state_q == ST_TRFC);
  assign sr_active    = (state_q == ST_SR);
  assign pending_cnt  = pending_q;
  assign ref_overflow = overflow_q;

`ifdef MC_REF_URGENT_STATS_EN
  logic [15:0] urgent_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      urgent_cycles_q <= 16'd0;
    end else if (ref_urgent && (urgent_cycles_q != 16'hFFFF)) begin
      urgent_cycles_q <= urgent_cycles_q + 16'd1;
    end
  end

  assign urgent_cycles = urgent_cycles_q;
`endif

endmodule

// File: tb/tb_mc_refresh_scheduler.sv
// Bench for mc_refresh_scheduler: directed vector table, reset corner sequences, and random
// stimulus compared against a cycle-level behavioural model (also covers MC_REF_URGENT_STATS_EN).
module tb_mc_refresh_scheduler;

  localparam int TREFI = 16;
  localparam int TRFC  = 4;
  localparam int MAXP  = 4;

  logic       clk = 1'b0;
  logic       reset, enable, ref_ack, sr_req, sr_exit;
  logic       ref_req, ref_urgent, busy_trfc, sr_active, ref_overflow;
  logic [3:0] pending_cnt;
`ifdef MC_REF_URGENT_STATS_EN
  logic [15:0] urgent_cycles;
`endif

  mc_refresh_scheduler #(
    .TREFI_CYC   (TREFI),
    .TRFC_CYC    (TRFC),
    .MAX_POSTPONE(MAXP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ref_ack     (ref_ack),
    .sr_req      (sr_req),
    .sr_exit     (sr_exit),
    .ref_req     (ref_req),
    .ref_urgent  (ref_urgent),
    .busy_trfc   (busy_trfc),
    .sr_active   (sr_active),
    .pending_cnt (pending_cnt),
    .ref_overflow(ref_overflow)
`ifdef MC_REF_URGENT_STATS_EN
    ,
    .urgent_cycles(urgent_cycles)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: mode 0=idle, 1=refresh busy, 2=self-refresh
  int m_mode, m_until_tick, m_busy_left, m_pend, m_ovf, m_urg;

  task automatic model_reset();
    m_mode = 0; m_until_tick = TREFI - 1; m_busy_left = 0;
    m_pend = 0; m_ovf = 0; m_urg = 0;
  endtask

  task automatic model_step(input bit en, input bit ack, input bit sr, input bit sx);
    bit t, taken;
    t     = (m_mode != 2) && en && (m_until_tick == 0);
    taken = (m_mode == 0) && (m_pend > 0) && ack;
    if (m_mode != 2 && m_pend == MAXP && m_urg < 65535) m_urg++;
    if (m_mode == 2)  m_until_tick = TREFI - 1;
    else if (en)      m_until_tick = t ? TREFI - 1 : m_until_tick - 1;
    if (m_mode == 2) begin
      m_pend = sx ? 1 : 0;
      if (sx) m_mode = 0;
    end else begin
      int p;
      p = m_pend + int'(t) - int'(taken);
      if (p > MAXP) begin p = MAXP; m_ovf = 1; end
      if (m_mode == 0) begin
        if (taken) begin m_mode = 1; m_busy_left = TRFC; end
        else if (sr && m_pend == 0) begin m_mode = 2; p = 0; end
      end else begin
        m_busy_left--;
        if (m_busy_left == 0) m_mode = 0;
      end
      m_pend = p;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " ref_req"},      int'(ref_req),      int'(m_mode == 0 && m_pend != 0));
    chk({tag, " busy_trfc"},    int'(busy_trfc),    int'(m_mode == 1));
    chk({tag, " sr_active"},    int'(sr_active),    int'(m_mode == 2));
    chk({tag, " pending_cnt"},  int'(pending_cnt),  m_pend);
    chk({tag, " ref_urgent"},   int'(ref_urgent),   int'(m_mode != 2 && m_pend == MAXP));
    chk({tag, " ref_overflow"}, int'(ref_overflow), m_ovf);
`ifdef MC_REF_URGENT_STATS_EN
    chk({tag, " urgent_cycles"}, int'(urgent_cycles), m_urg);
`endif
  endtask

  task automatic cyc(input bit en, input bit ack, input bit sr, input bit sx);
    enable = en; ref_ack = ack; sr_req = sr; sr_exit = sx;
    model_step(en, ack, sr, sx);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; ref_ack = 1'b0; sr_req = 1'b0; sr_exit = 1'b0;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
  endtask

  typedef struct {
    int n;
    bit en, ack, sr, sx;
    int req, busy, sra, pend, urg, ovf;
  } vec_t;

  vec_t tbl[25];

  initial begin
    tbl[0]  = '{15, 1,0,0,0, 0,0,0,0,0,0};
    tbl[1]  = '{ 1, 1,0,0,0, 1,0,0,1,0,0};
    tbl[2]  = '{ 1, 1,1,0,0, 0,1,0,0,0,0};
    tbl[3]  = '{ 3, 1,0,0,0, 0,1,0,0,0,0};
    tbl[4]  = '{ 1, 1,0,0,0, 0,0,0,0,0,0};
    tbl[5]  = '{11, 1,0,0,0, 1,0,0,1,0,0};
    tbl[6]  = '{48, 1,0,0,0, 1,0,0,4,1,0};
    tbl[7]  = '{15, 1,0,0,0, 1,0,0,4,1,0};
    tbl[8]  = '{ 1, 1,1,0,0, 0,1,0,4,1,0};
    tbl[9]  = '{ 4, 1,0,0,0, 1,0,0,4,1,0};
    tbl[10] = '{12, 1,0,0,0, 1,0,0,4,1,1};
    tbl[11] = '{ 1, 1,1,0,0, 0,1,0,3,0,1};
    tbl[12] = '{ 4, 1,0,0,0, 1,0,0,3,0,1};
    tbl[13] = '{ 1, 1,1,0,0, 0,1,0,2,0,1};
    tbl[14] = '{ 4, 1,0,0,0, 1,0,0,2,0,1};
    tbl[15] = '{ 1, 0,1,1,0, 0,1,0,1,0,1};
    tbl[16] = '{ 4, 0,0,1,0, 1,0,0,1,0,1};
    tbl[17] = '{ 1, 0,1,1,0, 0,1,0,0,0,1};
    tbl[18] = '{ 4, 0,0,1,0, 0,0,0,0,0,1};
    tbl[19] = '{ 1, 0,0,1,0, 0,0,1,0,0,1};
    tbl[20] = '{ 3, 1,0,0,0, 0,0,1,0,0,1};
    tbl[21] = '{ 1, 1,0,0,1, 1,0,0,1,0,1};
    tbl[22] = '{16, 1,0,0,0, 1,0,0,2,0,1};
    tbl[23] = '{ 1, 1,0,0,1, 1,0,0,2,0,1};
    tbl[24] = '{ 1, 0,1,0,0, 0,1,0,1,0,1};

    do_reset();
    chk("reset ref_req",      int'(ref_req),      0);
    chk("reset busy_trfc",    int'(busy_trfc),    0);
    chk("reset sr_active",    int'(sr_active),    0);
    chk("reset pending_cnt",  int'(pending_cnt),  0);
    chk("reset ref_urgent",   int'(ref_urgent),   0);
    chk("reset ref_overflow", int'(ref_overflow), 0);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < tbl[r].n; k++) cyc(tbl[r].en, tbl[r].ack, tbl[r].sr, tbl[r].sx);
      chk($sformatf("row%0d ref_req", r),      int'(ref_req),      tbl[r].req);
      chk($sformatf("row%0d busy_trfc", r),    int'(busy_trfc),    tbl[r].busy);
      chk($sformatf("row%0d sr_active", r),    int'(sr_active),    tbl[r].sra);
      chk($sformatf("row%0d pending_cnt", r),  int'(pending_cnt),  tbl[r].pend);
      chk($sformatf("row%0d ref_urgent", r),   int'(ref_urgent),   tbl[r].urg);
      chk($sformatf("row%0d ref_overflow", r), int'(ref_overflow), tbl[r].ovf);
      cmp_model($sformatf("row%0d model", r));
      $display("row %0d: n=%0d en=%0b ack=%0b sr=%0b sx=%0b -> req=%0b busy=%0b sra=%0b pend=%0d urg=%0b ovf=%0b",
               r, tbl[r].n, tbl[r].en, tbl[r].ack, tbl[r].sr, tbl[r].sx,
               ref_req, busy_trfc, sr_active, pending_cnt, ref_urgent, ref_overflow);
    end

    // Reset asserted in the middle of a tRFC window
    do_reset();
    for (int k = 0; k < 16; k++) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("midtrfc busy before reset", int'(busy_trfc), 1);
    do_reset();
    chk("midtrfc busy_trfc", int'(busy_trfc),   0);
    chk("midtrfc pending",   int'(pending_cnt), 0);
    chk("midtrfc ref_req",   int'(ref_req),     0);
    for (int k = 0; k < 15; k++) cyc(1, 0, 0, 0);
    chk("midtrfc counter reloaded", int'(pending_cnt), 0);
    $display("seq mid-tRFC reset: busy=%0b pend=%0d", busy_trfc, pending_cnt);

    // Reset asserted while in self-refresh
    do_reset();
    cyc(1, 0, 1, 0);
    chk("midsr sr_active before reset", int'(sr_active), 1);
    cyc(1, 0, 1, 0);
    do_reset();
    chk("midsr sr_active", int'(sr_active), 0);
    chk("midsr pending",   int'(pending_cnt), 0);
    $display("seq mid-SR reset: sra=%0b pend=%0d", sr_active, pending_cnt);

    // Randomized traffic against the model
    do_reset();
    begin
      bit sr_lvl;
      int ack_pct;
      sr_lvl = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        bit en, ack, sx;
        if (i % 500 == 0) ack_pct = $urandom_range(2, 40);
        if ($urandom_range(0, 149) == 0) sr_lvl = ~sr_lvl;
        en  = ($urandom_range(0, 9) != 0);
        ack = ($urandom_range(0, 99) < ack_pct);
        sx  = ($urandom_range(0, 29) == 0);
        cyc(en, ack, sr_lvl, sx);
        cmp_model($sformatf("rand%0d", i));
      end
    end
    $display("random phase: 4000 cycles, final pend=%0d ovf=%0b", pending_cnt, ref_overflow);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
